// File: rtl/ppfifo_axis_pkg.sv
// Shared types and constants for the PPFIFO-to-AXI-Stream reader: FSM encoding,
// PPFIFO size width and the index of the tag bit above each data word.
package ppfifo_axis_pkg;

    localparam int unsigned PpfifoSizeWidth = 24;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StActive  = 2'd1,
        StRelease = 2'd2
    } state_e;

    // The tag bit sits directly above the data word.
    function automatic int unsigned last_bit_idx(input int unsigned data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/axis_out_buffer2.sv
// Two-entry FIFO with registered outputs; the head register drives the stream
// directly so TDATA/TLAST never change while valid is held without ready.
module axis_out_buffer2 #(
    parameter int unsigned Width = 33
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    output logic             full_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o
);

    logic [1:0]       count_q, count_d;
    logic [Width-1:0] head_q, head_d;
    logic [Width-1:0] tail_q, tail_d;
    logic             push_ok;
    logic             pop;

    assign full_o  = (count_q == 2'd2);
    assign valid_o = (count_q != 2'd0);
    assign data_o  = head_q;
    assign push_ok = push_i && !full_o;
    assign pop     = valid_o && ready_i;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push_ok, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = data_i;
                end else begin
                    tail_d = data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                end
                count_d = count_q - 2'd1;
            end
            // push_ok implies not full and pop implies not empty, so exactly one entry.
            2'b11: head_d = data_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/ppfifo_2_axi_stream_reader.sv
// Drains PPFIFO read blocks onto an AXI4-Stream master; the stored tag bit becomes TLAST.
// Optional PPFIFO_AXIS_BLOCK_LAST_EN also forces TLAST on the final word of each block.
module ppfifo_2_axi_stream_reader
    import ppfifo_axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STROBE_WIDTH = DATA_WIDTH / 8
) (
    input  logic                       i_axi_clk,
    input  logic                       rst_n,
    output logic                       o_ppfifo_clk,
    input  logic                       i_ppfifo_rdy,
    output logic                       o_ppfifo_act,
    input  logic [PpfifoSizeWidth-1:0] i_ppfifo_size,
    output logic                       o_ppfifo_stb,
    input  logic [DATA_WIDTH:0]        i_ppfifo_data,
    output logic                       o_axi_valid,
    input  logic                       i_axi_ready,
    output logic [DATA_WIDTH-1:0]      o_axi_data,
    output logic [STROBE_WIDTH-1:0]    o_axi_keep,
    output logic                       o_axi_last
);

    localparam int unsigned LastIdx = last_bit_idx(DATA_WIDTH);
    localparam logic [PpfifoSizeWidth-1:0] SizeOne = 1;

    state_e                     state_q, state_d;
    logic                       act_q, act_d;
    logic [PpfifoSizeWidth-1:0] count_q, count_d;
    logic [PpfifoSizeWidth-1:0] size_q, size_d;
    logic                       has_room;
    logic                       buf_full;
    logic [DATA_WIDTH:0]        push_word;
    logic [DATA_WIDTH:0]        head_word;

    assign o_ppfifo_clk = i_axi_clk;
    assign o_ppfifo_act = act_q;
    assign has_room     = (count_q < size_q);
    assign o_ppfifo_stb = act_q && has_room && !buf_full;

    always_comb begin
        push_word = i_ppfifo_data;
`ifdef PPFIFO_AXIS_BLOCK_LAST_EN
        if (count_q == size_q - SizeOne) begin
            push_word[LastIdx] = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        count_d = count_q;
        size_d  = size_q;
        unique case (state_q)
            StIdle: begin
                if (i_ppfifo_rdy) begin
                    act_d   = 1'b1;
                    size_d  = i_ppfifo_size;
                    count_d = '0;
                    state_d = StActive;
                end
            end
            StActive: begin
                if (!has_room) begin
                    act_d   = 1'b0;
                    state_d = StRelease;
                end else if (o_ppfifo_stb) begin
                    count_d = count_q + SizeOne;
                end
            end
            // Dead cycle so the FIFO can swap banks before the next acquire.
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_axi_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            act_q   <= 1'b0;
            count_q <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            count_q <= count_d;
            size_q  <= size_d;
        end
    end

    axis_out_buffer2 #(
        .Width (DATA_WIDTH + 1)
    ) u_out_buf (
        .clk_i   (i_axi_clk),
        .rst_ni  (rst_n),
        .push_i  (o_ppfifo_stb),
        .data_i  (push_word),
        .full_o  (buf_full),
        .valid_o (o_axi_valid),
        .ready_i (i_axi_ready),
        .data_o  (head_word)
    );

    assign o_axi_data = head_word[DATA_WIDTH-1:0];
    assign o_axi_last = head_word[LastIdx];
    assign o_axi_keep = {STROBE_WIDTH{1'b1}};

endmodule

// File: tb/tb_ppfifo_2_axi_stream_reader.sv
// Self-checking bench: a PPFIFO source model feeds blocks, the expected stream is the
// concatenation of all block words (tag as TLAST), checked beat by beat.
module tb_ppfifo_2_axi_stream_reader;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ppfifo_clk;
    logic          rdy;
    logic          act;
    logic [23:0]   size;
    logic          stb;
    logic [DW:0]   pdata;
    logic          valid;
    logic          ready = 1'b0;
    logic [DW-1:0] data;
    logic [SW-1:0] keep;
    logic          last;

    always #5 clk = ~clk;

    ppfifo_2_axi_stream_reader #(
        .DATA_WIDTH   (DW),
        .STROBE_WIDTH (SW)
    ) dut (
        .i_axi_clk     (clk),
        .rst_n         (rst_n),
        .o_ppfifo_clk  (ppfifo_clk),
        .i_ppfifo_rdy  (rdy),
        .o_ppfifo_act  (act),
        .i_ppfifo_size (size),
        .o_ppfifo_stb  (stb),
        .i_ppfifo_data (pdata),
        .o_axi_valid   (valid),
        .i_axi_ready   (ready),
        .o_axi_data    (data),
        .o_axi_keep    (keep),
        .o_axi_last    (last)
    );

    // PPFIFO source model: queue of blocks, first-word-fall-through read pointer.
    logic [DW:0] src_mem   [0:1023];
    logic [23:0] blk_size  [0:63];
    logic [9:0]  wr_words  = '0;
    logic [5:0]  blk_count = '0;
    logic [9:0]  rd_ptr    = '0;
    logic [5:0]  blk_head  = '0;
    logic        act_prev  = 1'b0;
    int          pop_cnt   = 0;

    assign rdy   = (blk_head < blk_count) && !act;
    assign size  = blk_size[blk_head];
    assign pdata = src_mem[rd_ptr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= wr_words;
            blk_head <= blk_count;
            act_prev <= 1'b0;
            pop_cnt  <= 0;
        end else begin
            act_prev <= act;
            if (act && !act_prev) blk_head <= blk_head + 6'd1;
            if (stb) begin
                rd_ptr  <= rd_ptr + 10'd1;
                pop_cnt <= pop_cnt + 1;
            end
        end
    end

    // Expected stream and run statistics.
    logic [DW:0] exp_mem [0:1023];
    logic [9:0]  exp_wr = '0;
    logic [9:0]  exp_rd = '0;
    int          consumed = 0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          pops, beats, lasts, act_hi;
    int          first_pop, last_pop, first_beat, last_beat, act_fall;
    int          low_run, last_gap;
    logic        prev_act_n;
    logic        held;
    logic [DW:0] held_word;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        pops = 0; beats = 0; lasts = 0; act_hi = 0;
        first_pop = -1; last_pop = -1; first_beat = -1; last_beat = -1; act_fall = -1;
        low_run = 0; last_gap = -1; prev_act_n = act; held = 1'b0;
    endtask

    // mode 0: sequential from base, tag on final word; 1: random; 2: sequential, tags 0.
    task automatic enqueue(input int sz, input int mode, input logic [DW-1:0] base);
        logic [DW:0] w;
        logic [DW:0] e;
        for (int i = 0; i < sz; i++) begin
            if (mode == 1) w = {1'($urandom_range(1, 0)), 32'($urandom)};
            else w = {1'((mode == 0) && (i == sz - 1)), base + DW'(i)};
            e = w;
`ifdef PPFIFO_AXIS_BLOCK_LAST_EN
            if (i == sz - 1) e[DW] = 1'b1;
`endif
            src_mem[wr_words] = w;
            exp_mem[exp_wr]   = e;
            wr_words = wr_words + 10'd1;
            exp_wr   = exp_wr + 10'd1;
        end
        blk_size[blk_count] = 24'(sz);
        blk_count = blk_count + 6'd1;
    endtask

    // Called at a falling edge: check outputs, drive ready, advance one cycle.
    task automatic step(input logic rdy_axi);
        if (held) begin
            chk("stable_valid", 64'(valid), 64'(1));
            chk("stable_word", 64'({last, data}), 64'(held_word));
            held = 1'b0;
        end
        if (valid) begin
            chk("beat_expected", 64'(exp_rd != exp_wr), 64'(1));
            chk("beat_word", 64'({last, data}), 64'(exp_mem[exp_rd]));
            chk("keep", 64'(keep), 64'({SW{1'b1}}));
        end
        chk("pop_ahead", 64'((pop_cnt - consumed) <= 2), 64'(1));
        if (stb) begin
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            pops++;
        end
        if (act) begin
            act_hi++;
            if (!prev_act_n && low_run > 0) last_gap = low_run;
            low_run = 0;
        end else begin
            if (prev_act_n) act_fall = cyc;
            low_run++;
        end
        prev_act_n = act;
        ready = rdy_axi;
        if (valid && rdy_axi) begin
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
            beats++;
            if (last) lasts++;
            exp_rd = exp_rd + 10'd1;
            consumed++;
        end else if (valid) begin
            held = 1'b1;
            held_word = {last, data};
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // rmode 0: ready high; 1: pattern 1,0,0,1; 2: random.
    task automatic drain(input int rmode);
        int k;
        logic r;
        k = 0;
        while (!(exp_rd == exp_wr && blk_head == blk_count && !act) && k < 600) begin
            r = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((k % 4) == 0 || (k % 4) == 3)
                                                   : 1'($urandom_range(1, 0));
            step(r);
            k++;
        end
        chk("drain_timeout", 64'(k < 600), 64'(1));
        for (int i = 0; i < 3; i++) step(1'b1);
    endtask

    initial begin
        int k;
        #1;
        chk("rst_act", 64'(act), 64'(0));
        chk("rst_valid", 64'(valid), 64'(0));
        chk("rst_data", 64'(data), 64'(0));
        chk("rst_last", 64'(last), 64'(0));
        chk("rst_stb", 64'(stb), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clr_stats();

        // Idle: no blocks offered for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            chk("idle_quiet", 64'({act, valid, last, stb}), 64'(0));
            step(1'b1);
        end

        // Streaming block of 8, tag on final word.
        clr_stats();
        enqueue(8, 0, 32'h100);
        drain(0);
        chk("stream_beats", 64'(beats), 64'(8));
        chk("stream_pops", 64'(pops), 64'(8));
        chk("stream_consecutive", 64'(last_beat - first_beat), 64'(7));
        chk("stream_pop_span", 64'(last_pop - first_pop), 64'(7));
        chk("stream_latency", 64'(first_beat - first_pop), 64'(1));
        chk("stream_lasts", 64'(lasts), 64'(1));
        chk("stream_act_fall", 64'(act_fall - last_pop), 64'(2));

        // Backpressure, ready 1,0,0,1.
        clr_stats();
        enqueue(16, 1, 32'h0);
        drain(1);
        chk("bp_beats", 64'(beats), 64'(16));
        chk("bp_pops", 64'(pops), 64'(16));

        // Zero-size block.
        clr_stats();
        enqueue(0, 0, 32'h0);
        drain(0);
        chk("zero_act_cycles", 64'(act_hi), 64'(1));
        chk("zero_pops", 64'(pops), 64'(0));
        chk("zero_beats", 64'(beats), 64'(0));

        // Back-to-back blocks of 4.
        clr_stats();
        enqueue(4, 0, 32'h200);
        enqueue(4, 0, 32'h300);
        drain(0);
        chk("b2b_beats", 64'(beats), 64'(8));
        chk("b2b_gap", 64'(last_gap >= 1 && last_gap <= 2), 64'(1));
        chk("b2b_lasts", 64'(lasts), 64'(2));

        // Random blocks with random backpressure.
        clr_stats();
        for (int b = 0; b < 5; b++) enqueue(int'($urandom_range(12, 0)), 1, 32'h0);
        drain(2);

        // Reset mid-block after 3 of 10 pops.
        clr_stats();
        enqueue(10, 0, 32'h400);
        k = 0;
        while (pops < 3 && k < 50) begin
            step(1'b1);
            k++;
        end
        chk("mid_reach3", 64'(pops), 64'(3));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_quiet", 64'({act, valid, last, stb}), 64'(0));
        chk("mid_rst_data", 64'(data), 64'(0));
        exp_rd = exp_wr;
        consumed = 0;
        @(negedge clk);
        rst_n = 1'b1;
        clr_stats();
        enqueue(4, 2, 32'h500);
        drain(0);
        chk("post_rst_beats", 64'(beats), 64'(4));
`ifdef PPFIFO_AXIS_BLOCK_LAST_EN
        chk("post_rst_lasts", 64'(lasts), 64'(1));
`else
        chk("post_rst_lasts", 64'(lasts), 64'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
